// File: rtl/duck_pkg.sv
// Shared types and constants for the duck flight controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package duck_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLY    = 3'd1,
    HIT    = 3'd2,
    FALL   = 3'd3,
    ESCAPE = 3'd4
  } duck_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 48;

  // Galois feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_POLY = 16'hB400;

endpackage

// File: rtl/duck_lfsr16.sv
// 16-bit Galois LFSR used as the spawn position/direction source.
// Latency: advances once per clk, output registered.
// Backpressure: none, free-running.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);
  import duck_pkg::*;

  // Right shift, folding the tap polynomial in whenever a one falls out of bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
  end

endmodule

// File: rtl/duck_ctl.sv
// Per-duck flight controller: spawn, bounce flight, hit freeze, fall, escape.
// Latency: every output updates one clk after the triggering start/shot_hit/new_frame.
// Backpressure: none; inputs are sampled pulses, ignored outside their honouring state.
module duck_ctl #(
  parameter int          SPEED_X    = 2,
  parameter int          SPEED_Y    = 2,
  parameter int          FALL_SPEED = 4,
  parameter int          HIT_FRAMES = 30,
  parameter int          FLY_FRAMES = 300,
  parameter int          X_MAX      = 576,
  parameter int          Y_MIN      = 16,
  parameter int          Y_MAX      = 360,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       start,
  input  logic       shot_hit,
  output logic [9:0] duck_x,
  output logic [9:0] duck_y,
  output logic       duck_direction,
  output logic       duck_show,
  output logic       duck_hit,
  output logic       busy,
  output logic       duck_killed,
  output logic       duck_escaped
);
  import duck_pkg::*;

  // 11-bit forms of the limits so additions never wrap during compares
  localparam logic [10:0] SX_W    = 11'(SPEED_X);
  localparam logic [10:0] SY_W    = 11'(SPEED_Y);
  localparam logic [10:0] FS_W    = 11'(FALL_SPEED);
  localparam logic [10:0] XMAX_W  = 11'(X_MAX);
  localparam logic [10:0] YMIN_W  = 11'(Y_MIN);
  localparam logic [10:0] YMAX_W  = 11'(Y_MAX);
  localparam logic [15:0] FLY_CNT = 16'(FLY_FRAMES);
  localparam logic [15:0] HIT_CNT = 16'(HIT_FRAMES);

  duck_state_t state, state_n;
  logic [9:0]  x_n, y_n;
  logic        dir_n, show_n, hit_n, killed_n, escaped_n;
  logic        v_up, v_up_n;
  logic [15:0] frame_cnt, frame_cnt_n;
  logic [15:0] lfsr;
  logic [10:0] x_w, y_w;
  logic        unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign x_w         = {1'b0, duck_x};
  assign y_w         = {1'b0, duck_y};
  assign busy        = (state != IDLE);
  assign unused_lfsr = ^lfsr[15:10];

  // State, position and outcome registers; reset restores the parked duck.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      duck_x         <= 10'd0;
      duck_y         <= 10'(Y_MAX);
      duck_direction <= 1'b1;
      v_up           <= 1'b1;
      duck_show      <= 1'b0;
      duck_hit       <= 1'b0;
      duck_killed    <= 1'b0;
      duck_escaped   <= 1'b0;
      frame_cnt      <= 16'd0;
    end else begin
      state          <= state_n;
      duck_x         <= x_n;
      duck_y         <= y_n;
      duck_direction <= dir_n;
      v_up           <= v_up_n;
      duck_show      <= show_n;
      duck_hit       <= hit_n;
      duck_killed    <= killed_n;
      duck_escaped   <= escaped_n;
      frame_cnt      <= frame_cnt_n;
    end
  end

  // Next state and next position; a hit in FLY pre-empts both motion and timeout.
  always_comb begin
    state_n     = state;
    x_n         = duck_x;
    y_n         = duck_y;
    dir_n       = duck_direction;
    v_up_n      = v_up;
    show_n      = duck_show;
    hit_n       = duck_hit;
    killed_n    = 1'b0;
    escaped_n   = 1'b0;
    frame_cnt_n = frame_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          state_n     = FLY;
          x_n         = {1'b0, lfsr[8:0]};
          dir_n       = lfsr[9];
          y_n         = YMAX_W[9:0];
          v_up_n      = 1'b1;
          frame_cnt_n = 16'd0;
          show_n      = 1'b1;
          hit_n       = 1'b0;
        end
      end

      FLY: begin
        if (shot_hit) begin
          state_n     = HIT;
          hit_n       = 1'b1;
          frame_cnt_n = 16'd0;
        end else if (new_frame) begin
          frame_cnt_n = frame_cnt + 16'd1;
          if (duck_direction) begin
            if (x_w + SX_W >= XMAX_W) begin
              x_n   = XMAX_W[9:0];
              dir_n = 1'b0;
            end else begin
              x_n = duck_x + SX_W[9:0];
            end
          end else begin
            if (x_w <= SX_W) begin
              x_n   = 10'd0;
              dir_n = 1'b1;
            end else begin
              x_n = duck_x - SX_W[9:0];
            end
          end
          if (v_up) begin
            if (y_w <= YMIN_W + SY_W) begin
              y_n    = YMIN_W[9:0];
              v_up_n = 1'b0;
            end else begin
              y_n = duck_y - SY_W[9:0];
            end
          end else begin
            if (y_w + SY_W >= YMAX_W) begin
              y_n    = YMAX_W[9:0];
              v_up_n = 1'b1;
            end else begin
              y_n = duck_y + SY_W[9:0];
            end
          end
          if (frame_cnt_n >= FLY_CNT) state_n = ESCAPE;
        end
      end

      HIT: begin
        if (new_frame) begin
          frame_cnt_n = frame_cnt + 16'd1;
          if (frame_cnt_n >= HIT_CNT) state_n = FALL;
        end
      end

      FALL: begin
        if (new_frame) begin
          if (y_w + FS_W >= YMAX_W) begin
            y_n      = YMAX_W[9:0];
            show_n   = 1'b0;
            hit_n    = 1'b0;
            killed_n = 1'b1;
            state_n  = IDLE;
          end else begin
            y_n = duck_y + FS_W[9:0];
          end
        end
      end

      ESCAPE: begin
        if (new_frame) begin
          if (y_w <= SY_W) begin
            y_n       = 10'd0;
            show_n    = 1'b0;
            escaped_n = 1'b1;
            state_n   = IDLE;
          end else begin
            y_n = duck_y - SY_W[9:0];
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_duck_ctl.sv
// Randomized bench for duck_ctl against a velocity/clamp reference model.
// Latency: model expects every output one clk after the stimulus cycle.
// Backpressure: n/a.
module tb_duck_ctl;
  localparam int          SX    = 2;
  localparam int          SY    = 2;
  localparam int          FS    = 4;
  localparam int          HITF  = 30;
  localparam int          FLYF  = 300;
  localparam int          XMAX  = 512;
  localparam int          YMIN  = 16;
  localparam int          YMAX  = 360;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] POLY  = 16'hB400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_frame = 1'b0;
  logic       start = 1'b0;
  logic       shot_hit = 1'b0;
  logic [9:0] duck_x, duck_y;
  logic       duck_direction, duck_show, duck_hit, busy, duck_killed, duck_escaped;

  duck_ctl #(
    .SPEED_X(SX), .SPEED_Y(SY), .FALL_SPEED(FS), .HIT_FRAMES(HITF),
    .FLY_FRAMES(FLYF), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start(start), .shot_hit(shot_hit),
    .duck_x(duck_x), .duck_y(duck_y), .duck_direction(duck_direction),
    .duck_show(duck_show), .duck_hit(duck_hit), .busy(busy),
    .duck_killed(duck_killed), .duck_escaped(duck_escaped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int kills = 0;
  int escapes = 0;

  // Reference model: phase 0 idle, 1 fly, 2 hit, 3 fall, 4 escape; signed velocities.
  int          m_phase, mx, my, mvx, mvy, m_frames;
  bit          m_show, m_hit, m_kill, m_esc;
  logic [15:0] m_lfsr;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_phase = 0; mx = 0; my = YMAX; mvx = SX; mvy = -SY; m_frames = 0;
    m_show = 0; m_hit = 0; m_kill = 0; m_esc = 0; m_lfsr = SEED;
  endtask

  task automatic model_step(input bit st, input bit sh, input bit nf);
    m_kill = 0;
    m_esc  = 0;
    case (m_phase)
      0: if (st) begin
        mx = int'(m_lfsr[8:0]);
        mvx = m_lfsr[9] ? SX : -SX;
        my = YMAX; mvy = -SY; m_frames = 0; m_show = 1; m_hit = 0; m_phase = 1;
      end
      1: if (sh) begin
        m_phase = 2; m_hit = 1; m_frames = 0;
      end else if (nf) begin
        m_frames++;
        mx += mvx;
        if (mx >= XMAX) begin mx = XMAX; mvx = -SX; end
        else if (mx <= 0) begin mx = 0; mvx = SX; end
        my += mvy;
        if (mvy < 0 && my <= YMIN) begin my = YMIN; mvy = SY; end
        else if (mvy > 0 && my >= YMAX) begin my = YMAX; mvy = -SY; end
        if (m_frames >= FLYF) m_phase = 4;
      end
      2: if (nf) begin
        m_frames++;
        if (m_frames >= HITF) m_phase = 3;
      end
      3: if (nf) begin
        my += FS;
        if (my >= YMAX) begin my = YMAX; m_show = 0; m_hit = 0; m_kill = 1; m_phase = 0; end
      end
      4: if (nf) begin
        my -= SY;
        if (my <= 0) begin my = 0; m_show = 0; m_esc = 1; m_phase = 0; end
      end
      default: m_phase = 0;
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic compare_all();
    check("x", 16'(duck_x), 16'(mx));
    check("y", 16'(duck_y), 16'(my));
    check("dir", 16'(duck_direction), 16'(mvx > 0));
    check("show", 16'(duck_show), 16'(m_show));
    check("hit", 16'(duck_hit), 16'(m_hit));
    check("busy", 16'(busy), 16'(m_phase != 0));
    check("killed", 16'(duck_killed), 16'(m_kill));
    check("escaped", 16'(duck_escaped), 16'(m_esc));
    if (duck_killed) kills++;
    if (duck_escaped) escapes++;
  endtask

  // Drive one clk of stimulus from a negedge, then compare after the posedge.
  task automatic cycle(input bit st, input bit sh, input bit nf);
    start = st; shot_hit = sh; new_frame = nf;
    @(posedge clk); #1;
    model_step(st, sh, nf);
    compare_all();
    @(negedge clk);
    start = 1'b0; shot_hit = 1'b0; new_frame = 1'b0;
  endtask

  task automatic one_frame(input bit allow_st, input bit allow_sh);
    int gap;
    bit st, sh;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      st = allow_st && ($urandom_range(0, 1) == 1);
      sh = allow_sh && ($urandom_range(0, 1) == 1);
      cycle(st, sh, 1'b0);
    end
    sh = allow_sh && ($urandom_range(0, 3) == 0);
    cycle(1'b0, sh, 1'b1);
  endtask

  task automatic run_frames(input int n, input bit allow_st, input bit allow_sh);
    for (int i = 0; i < n; i++) one_frame(allow_st, allow_sh);
  endtask

  task automatic run_until(input int target, input int max_frames, input bit allow_st,
                           input bit allow_sh, output bit reached);
    reached = (m_phase == target);
    for (int i = 0; i < max_frames && !reached; i++) begin
      one_frame(allow_st, allow_sh);
      reached = (m_phase == target);
    end
  endtask

  initial begin
    logic [15:0] s;
    int  n0;
    int  kills_before;
    bit  ok;
    logic [9:0] sx, sy;

    model_reset();
    s  = SEED;
    n0 = -1;
    for (int n = 1; n < 70000 && n0 < 0; n++) begin
      s = lfsr_next(s);
      if (s[9:0] == 10'h3FE) n0 = n;
    end

    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    check("lfsr_search_found", 16'(n0 > 0), 16'd1);
    if (n0 > 0) begin
      for (int i = 0; i < n0; i++) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      check("spawn_x", 16'(duck_x), 16'd510);
      check("spawn_dir", 16'(duck_direction), 16'd1);
      check("spawn_y", 16'(duck_y), 16'd360);
      check("spawn_show", 16'(duck_show), 16'd1);
      check("spawn_busy", 16'(busy), 16'd1);

      cycle(1'b0, 1'b0, 1'b1);
      check("edge_x", 16'(duck_x), 16'd512);
      check("edge_dir", 16'(duck_direction), 16'd0);
      cycle(1'b0, 1'b0, 1'b1);
      check("bounce_x", 16'(duck_x), 16'd510);

      run_frames(60, 1'b1, 1'b0);

      sx = duck_x; sy = duck_y;
      cycle(1'b1, 1'b0, 1'b0);
      check("start_in_fly_x", 16'(duck_x), 16'(sx));
      check("start_in_fly_y", 16'(duck_y), 16'(sy));

      cycle(1'b0, 1'b1, 1'b1);
      check("hit_frame_x", 16'(duck_x), 16'(sx));
      check("hit_frame_y", 16'(duck_y), 16'(sy));
      check("hit_flag", 16'(duck_hit), 16'd1);

      run_until(0, 250, 1'b1, 1'b1, ok);
      check("fall_done", 16'(ok), 16'd1);
      check("kill_count", 16'(kills), 16'd1);
      check("after_kill_show", 16'(duck_show), 16'd0);
      check("after_kill_busy", 16'(busy), 16'd0);
    end

    // Escape path: no shots for the whole flight
    kills_before = kills;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    run_until(4, FLYF + 5, 1'b1, 1'b0, ok);
    check("reach_escape", 16'(ok), 16'd1);
    run_until(0, 250, 1'b1, 1'b1, ok);
    check("escape_done", 16'(ok), 16'd1);
    check("escape_count", 16'(escapes), 16'd1);
    check("no_kill_on_escape", 16'(kills), 16'(kills_before));
    check("escape_y", 16'(duck_y), 16'd0);

    // Asynchronous reset in the middle of a fall
    cycle(1'b1, 1'b0, 1'b0);
    run_frames(40, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    run_until(3, HITF + 5, 1'b0, 1'b0, ok);
    run_frames(3, 1'b0, 1'b0);
    check("pre_rst_falling", 16'(busy && duck_hit && duck_show), 16'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_x", 16'(duck_x), 16'd0);
    check("arst_y", 16'(duck_y), 16'd360);
    check("arst_dir", 16'(duck_direction), 16'd1);
    check("arst_show", 16'(duck_show), 16'd0);
    check("arst_hit", 16'(duck_hit), 16'd0);
    check("arst_busy", 16'(busy), 16'd0);
    check("arst_killed", 16'(duck_killed), 16'd0);
    check("arst_escaped", 16'(duck_escaped), 16'd0);
    @(posedge clk); #1;
    check("arst_hold_killed", 16'(duck_killed), 16'd0);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/duck_ctl.md
# duck_ctl

Per-duck flight controller for the Duck Hunt VGA pipeline. It sequences one duck through spawn, flight with edge bounce, hit freeze, fall and escape. It drives the position, direction, visibility and hit-freeze inputs of the duck sprite drawing stage, and reports kill/escape outcomes to game logic. All motion advances once per video frame on `new_frame`.

## Interface
Parameters:
- `SPEED_X`, 2: horizontal step per frame in FLY, px.
- `SPEED_Y`, 2: vertical step per frame in FLY and ESCAPE, px.
- `FALL_SPEED`, 4: downward step per frame in FALL, px.
- `HIT_FRAMES`, 30: frames frozen after a hit.
- `FLY_FRAMES`, 300: frames in FLY before the duck escapes.
- `X_MAX`, 576: largest legal duck_x (640 − 64).
- `Y_MIN`, 16: top bounce limit in FLY.
- `Y_MAX`, 360: ground line for duck_y; also the spawn y.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `new_frame`, in, 1: one-cycle pulse per frame.
- `start`, in, 1: spawn request. Honoured only in IDLE.
- `shot_hit`, in, 1: one-cycle pulse when the shot landed on the duck. Honoured only in FLY.
- `duck_x`, out, 10: sprite left edge.
- `duck_y`, out, 10: sprite top edge.
- `duck_direction`, out, 1: 1 = moving +x (sprite unmirrored), 0 = moving −x.
- `duck_show`, out, 1: sprite visible.
- `duck_hit`, out, 1: animation freeze, high in HIT and FALL.
- `busy`, out, 1: state ≠ IDLE.
- `duck_killed`, out, 1: one-cycle pulse when the fall ends.
- `duck_escaped`, out, 1: one-cycle pulse when the escape ends.

## Operation
- LFSR: 16-bit Galois, polynomial 0xB400, shifts every clk (not gated by `new_frame`).
- States and transitions:
  - IDLE to FLY on `start`.
  - FLY to HIT on `shot_hit`.
  - FLY to ESCAPE when the frame count reaches `FLY_FRAMES`.
  - HIT to FALL after `HIT_FRAMES` frames.
  - FALL to IDLE at the ground.
  - ESCAPE to IDLE at the top.
- Spawn (IDLE with `start`):
  - duck_x = {1'b0, lfsr[8:0]}, giving 0..511.
  - duck_direction = lfsr[9].
  - duck_y = Y_MAX; vertical direction = up.
  - Frame count cleared; duck_show set to 1.
- FLY, on each `new_frame`:
  - Frame count increments.
  - Horizontal, moving +x: if x + SPEED_X ≥ X_MAX then x = X_MAX and direction flips to 0; else x += SPEED_X. Moving −x mirrors this with the limit 0.
  - Vertical, moving up: if y ≤ Y_MIN + SPEED_Y then y = Y_MIN and direction flips to down; else y −= SPEED_Y. Moving down: if y + SPEED_Y ≥ Y_MAX then y = Y_MAX and direction flips to up.
  - All compares are done at 11 bits, so there is no wrap.
- HIT: x and y frozen; duck_hit = 1; frame count cleared on entry.
- FALL, on each `new_frame`:
  - If y + FALL_SPEED ≥ Y_MAX: y = Y_MAX, duck_show = 0, duck_hit = 0, pulse `duck_killed`, go to IDLE.
  - Otherwise y += FALL_SPEED.
  - x is frozen throughout FALL.
- ESCAPE, on each `new_frame`:
  - If y ≤ SPEED_Y: y = 0, duck_show = 0, pulse `duck_escaped`, go to IDLE.
  - Otherwise y −= SPEED_Y.
  - x is frozen throughout ESCAPE.
- Simultaneous events:
  - `shot_hit` together with `new_frame` in FLY: the hit wins and no move is made that frame.
  - `shot_hit` together with the FLY timeout: the hit wins.
  - `start` outside IDLE: ignored.
  - `shot_hit` outside FLY: ignored.

## Timing
- All outputs are registered. Each update appears one cycle after the triggering `start`, `shot_hit` or `new_frame` cycle.
- `duck_killed` and `duck_escaped` are high for exactly one cycle, coincident with duck_show falling.
- Reset values:
  - State IDLE, duck_x 0, duck_y Y_MAX, duck_direction 1.
  - duck_show, duck_hit, busy, duck_killed, duck_escaped all 0.
  - Frame count 0, LFSR = LFSR_SEED.
- Reset asserted mid-flight: all of the above are restored immediately (asynchronous), with no outcome pulse.

## Structure
- Shared package `duck_pkg`: state enum `duck_state_t` (IDLE, FLY, HIT, FALL, ESCAPE), screen/sprite constants (640, 480, 64, 48), LFSR polynomial.
- One sub-module, `lfsr16`: clk, rst, seed parameter, 16-bit output. Remaining logic lives in `duck_ctl`: one state register process plus next-state/next-position combinational logic.

## Test plan
- Reset, then `start` exactly N clks after reset release: duck_x/duck_direction equal the bench LFSR model value at N; duck_y = 360; duck_show = 1 one cycle later; busy = 1.
- Flight moving +x with x near the edge (choose N so that spawn x = 510), override X_MAX = 512: the next `new_frame` gives x = 512 and direction 0; the following frame gives x = 510.
- `shot_hit` in FLY: duck_hit = 1 and x/y stable for 30 frames; then y rises by 4 per frame until 360; `duck_killed` pulses once; duck_show = 0; busy = 0.
- No shot for 300 frames: state becomes ESCAPE; y falls by 2 per frame to 0; `duck_escaped` single pulse; duck_killed never asserted.
- `shot_hit` and `new_frame` in the same cycle: position unchanged and HIT entered. `start` during FLY: no respawn, coordinates unaffected.
- Assert `rst` mid-FALL: outputs take reset values asynchronously, before the next clk edge; no outcome pulse.
